// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO and issuer driving a registered ALU, with one-entry result register
// Commands are issued one at a time; the result is captured after ALU_LAT edges and the flag class is checked.
module alu_cmd_issuer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [WIDTH-1:0]         i_cmd_a,
    input  logic [WIDTH-1:0]         i_cmd_b,
    input  logic [3:0]               i_cmd_fun,
    input  logic [TAG_W-1:0]         i_cmd_tag,
    output logic [$clog2(DEPTH):0]   o_cmd_level,
    output logic [WIDTH-1:0]         o_alu_a,
    output logic [WIDTH-1:0]         o_alu_b,
    output logic [3:0]               o_alu_fun,
    input  logic [WIDTH-1:0]         i_alu_out,
    input  logic [3:0]               i_alu_flag,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [WIDTH-1:0]         o_res_data,
    output logic [3:0]               o_res_flag,
    output logic [TAG_W-1:0]         o_res_tag,
    output logic                     o_flag_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam int EW = 2 * WIDTH + 4 + TAG_W;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [3:0]  FUN_NOP  = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [3:0]        r_alu_fun;
    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_data;
    logic [3:0]        r_res_flag;
    logic [TAG_W-1:0]  r_res_tag;
    logic              r_flag_err;

    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic [WIDTH-1:0]  w_head_a;
    logic [WIDTH-1:0]  w_head_b;
    logic [3:0]        w_head_fun;
    logic [TAG_W-1:0]  w_head_tag;

    function automatic logic [3:0] class_flag(input logic [3:0] fun);
        if (fun <= 4'd3)       return 4'b1000;
        else if (fun <= 4'd9)  return 4'b0100;
        else if (fun <= 4'd12) return 4'b0010;
        else                   return 4'b0001;
    endfunction

    assign o_cmd_ready = (r_level != LVL_FULL);
    assign w_push      = i_cmd_valid & o_cmd_ready;
    // Pops only from IDLE or on the result handshake, so a fresh push never bypasses the FIFO.
    assign w_pop       = (r_level != '0) &&
                         ((r_state == S_IDLE) || ((r_state == S_RESP) && i_res_ready));

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_a   = w_head[EW-1 -: WIDTH];
    assign w_head_b   = w_head[EW-1-WIDTH -: WIDTH];
    assign w_head_fun = w_head[TAG_W+3 -: 4];
    assign w_head_tag = w_head[TAG_W-1:0];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_a, i_cmd_b, i_cmd_fun, i_cmd_tag};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tag       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= FUN_NOP;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flag  <= '0;
            r_res_tag   <= '0;
            r_flag_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_a   <= w_head_a;
                        r_alu_b   <= w_head_b;
                        r_alu_fun <= w_head_fun;
                        r_tag     <= w_head_tag;
                        r_cnt     <= CW'(ALU_LAT);
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_res_data  <= i_alu_out;
                        r_res_flag  <= i_alu_flag;
                        r_res_tag   <= r_tag;
                        r_res_valid <= 1'b1;
                        r_flag_err  <= (r_alu_fun != FUN_NOP) &&
                                       (i_alu_flag != class_flag(r_alu_fun));
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a   <= w_head_a;
                            r_alu_b   <= w_head_b;
                            r_alu_fun <= w_head_fun;
                            r_tag     <= w_head_tag;
                            r_cnt     <= CW'(ALU_LAT);
                            r_state   <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_level = r_level;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_fun   = r_alu_fun;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_flag  = r_res_flag;
    assign o_res_tag   = r_res_tag;
    assign o_flag_err  = r_flag_err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a registered ALU model
// Directed commands push hand-computed results; a negedge monitor pops and compares on each handshake.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_fun = '0;
    logic [3:0]  cmd_tag = '0;
    logic [2:0]  cmd_level;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out = '0;
    logic [3:0]  alu_flag = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [3:0]  res_flag;
    logic [3:0]  res_tag;
    logic        flag_err;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(16), .DEPTH(4), .TAG_W(4), .ALU_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_fun(cmd_fun), .i_cmd_tag(cmd_tag),
        .o_cmd_level(cmd_level),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun),
        .i_alu_out(alu_out), .i_alu_flag(alu_flag),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_flag(res_flag), .o_res_tag(res_tag),
        .o_flag_err(flag_err)
    );

    function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] f);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (b != 16'd0) ? a / b : 16'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a & b);
            4'd7:  return ~(a | b);
            4'd8:  return a ^ b;
            4'd9:  return ~(a ^ b);
            4'd10: return (a == b) ? 16'd1 : 16'd0;
            4'd11: return (a > b) ? 16'd2 : 16'd0;
            4'd12: return (a < b) ? 16'd3 : 16'd0;
            4'd13: return a >> 1;
            4'd14: return a << 1;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] alu_class(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd3:                    return 4'b1000;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:        return 4'b0100;
            4'd10, 4'd11, 4'd12:                       return 4'b0010;
            default:                                   return 4'b0001;
        endcase
    endfunction

    // Registered ALU; FUN 15 holds outputs; A=0x0AAA with FUN 0 is a deliberately wrong flag.
    always @(posedge clk) begin
        if (alu_fun != 4'hF) begin
            alu_out  <= alu_calc(alu_a, alu_b, alu_fun);
            alu_flag <= (alu_fun == 4'd0 && alu_a == 16'h0AAA) ? 4'b0100 : alu_class(alu_fun);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            check("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("res_data", res_data, x.d);
                check("res_flag", res_flag, x.f);
                check("res_tag", res_tag, x.t);
                check("flag_err", flag_err, x.e);
            end
        end
    end

    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                            input logic [3:0] t, input logic [15:0] ed, input logic [3:0] ef,
                            input logic ee);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_fun = f; cmd_tag = t; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("push_ready", cmd_ready, 1);
        if (cmd_ready) exp_q.push_back('{d: ed, f: ef, t: t, e: ee});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin @(negedge clk); n++; end
        check(name, res_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 200) begin @(negedge clk); n++; end
        check(name, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_level", cmd_level, 0);
        check("rst_alu_fun", alu_fun, 4'hF);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_flag", res_flag, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_flag_err", flag_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;

        // Single command latency
        push_cmd(16'd4, 16'd3, 4'd0, 4'd1, 16'd7, 4'b1000, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 20);
        check("t1_latency", n - 1, 3);
        wait_drain("t1_drain");

        // Fill to DEPTH behind a stalled result, then drain in order
        res_ready = 1'b0;
        push_cmd(16'd1, 16'd1, 4'd0, 4'd0, 16'd2, 4'b1000, 1'b0);
        wait_valid("t2_blocker_valid");
        push_cmd(16'd7, 16'd6, 4'd4,  4'd2, 16'd6,  4'b0100, 1'b0);
        push_cmd(16'd7, 16'd6, 4'd11, 4'd3, 16'd2,  4'b0010, 1'b0);
        push_cmd(16'd7, 16'd0, 4'd13, 4'd4, 16'd3,  4'b0001, 1'b0);
        push_cmd(16'd7, 16'd0, 4'd14, 4'd5, 16'd14, 4'b0001, 1'b0);
        @(negedge clk);
        check("t2_level_full", cmd_level, 4);
        check("t2_ready_full", cmd_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t2_level_after_pop", cmd_level, 3);
        check("t2_ready_after_pop", cmd_ready, 1);
        wait_drain("t2_drain");

        // Simultaneous push and pop keeps the level
        res_ready = 1'b0;
        push_cmd(16'd2, 16'd3, 4'd0, 4'd10, 16'd5, 4'b1000, 1'b0);
        wait_valid("t6_blocker_valid");
        push_cmd(16'd9,  16'd4,  4'd1,  4'd11, 16'd5, 4'b1000, 1'b0);
        push_cmd(16'd3,  16'd5,  4'd12, 4'd12, 16'd3, 4'b0010, 1'b0);
        push_cmd(16'd12, 16'd10, 4'd8,  4'd13, 16'd6, 4'b0100, 1'b0);
        @(negedge clk);
        check("t6_level_before", cmd_level, 3);
        @(posedge clk); #1;
        cmd_a = 16'd5; cmd_b = 16'd3; cmd_fun = 4'd5; cmd_tag = 4'd14;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        exp_q.push_back('{d: 16'd7, f: 4'b0100, t: 4'd14, e: 1'b0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t6_level_same", cmd_level, 3);
        wait_drain("t6_drain");

        // Result held under back-pressure; queued command waits
        res_ready = 1'b0;
        push_cmd(16'd6, 16'd2, 4'd3,  4'd6, 16'd3, 4'b1000, 1'b0);
        push_cmd(16'd5, 16'd5, 4'd10, 4'd7, 16'd1, 4'b0010, 1'b0);
        wait_valid("t3_valid");
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_data", res_data, 3);
            check("t3_hold_flag", res_flag, 4'b1000);
            check("t3_queued_level", cmd_level, 1);
            check("t3_not_issued", alu_fun, 4'd3);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_drain("t3_drain");

        // Flag mismatch, then NOP returns the held ALU output
        push_cmd(16'h0AAA, 16'd1, 4'd0,  4'd8, 16'h0AAB, 4'b0100, 1'b1);
        push_cmd(16'd0,    16'd0, 4'd15, 4'd9, 16'h0AAB, 4'b0100, 1'b0);
        wait_drain("t4_drain");

        // Reset during WAIT with two commands queued
        push_cmd(16'd1, 16'd2, 4'd0, 4'd1, 16'd3,  4'b1000, 1'b0);
        push_cmd(16'd3, 16'd4, 4'd0, 4'd2, 16'd7,  4'b1000, 1'b0);
        push_cmd(16'd5, 16'd6, 4'd0, 4'd3, 16'd11, 4'b1000, 1'b0);
        check("t5_pre_level", cmd_level, 2);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t5_rst_level", cmd_level, 0);
        check("t5_rst_alu_fun", alu_fun, 4'hF);
        check("t5_rst_alu_a", alu_a, 0);
        check("t5_rst_res_valid", res_valid, 0);
        check("t5_rst_res_data", res_data, 0);
        check("t5_rst_flag_err", flag_err, 0);
        check("t5_rst_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        check("t5_no_result", n, 0);
        check("t5_level_after", cmd_level, 0);

        wait_drain("final_drain");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
